// File: rtl/m_ext_pkg.sv
// Shared definitions for the M-extension multiply controller: multiplier
// opcode encodings, funct3 constants, FSM states and opcode conversion helpers.
package m_ext_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

    typedef enum logic [2:0] {
        MULSEL_IDLE   = 3'd0,
        MULSEL_MUL    = 3'd1,
        MULSEL_MULH   = 3'd2,
        MULSEL_MULHSU = 3'd3,
        MULSEL_MULHU  = 3'd4
    } mulsel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic mulsel_e mulsel_from_funct3(input logic [2:0] f3);
        case (f3)
            FUNCT3_MUL:    return MULSEL_MUL;
            FUNCT3_MULH:   return MULSEL_MULH;
            FUNCT3_MULHSU: return MULSEL_MULHSU;
            FUNCT3_MULHU:  return MULSEL_MULHU;
            default:       return MULSEL_IDLE;
        endcase
    endfunction

    function automatic logic [2:0] funct3_from_mulsel(input mulsel_e sel);
        case (sel)
            MULSEL_MULH:   return FUNCT3_MULH;
            MULSEL_MULHSU: return FUNCT3_MULHSU;
            MULSEL_MULHU:  return FUNCT3_MULHU;
            default:       return FUNCT3_MUL;
        endcase
    endfunction

endpackage

// File: rtl/m_ext_result_cache.sv
// Single-entry result cache for the multiply controller. Remembers the last
// completed {funct3, rs1, rs2} -> product so an identical follow-up multiply
// can skip the external multiplier. Only built when MULT_CACHE_EN is defined.
module m_ext_result_cache
    import m_ext_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wr_en_i,
    input  logic [2:0]      wr_funct3_i,
    input  logic [XLEN-1:0] wr_a_i,
    input  logic [XLEN-1:0] wr_b_i,
    input  logic [XLEN-1:0] wr_res_i,
    input  logic [2:0]      rd_funct3_i,
    input  logic [XLEN-1:0] rd_a_i,
    input  logic [XLEN-1:0] rd_b_i,
    output logic            hit_o,
    output logic [XLEN-1:0] hit_res_o
);

    logic            valid_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] res_q;

    // Entry valid bit: reset invalidates, any completed multiply validates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else if (wr_en_i) begin
            valid_q <= 1'b1;
        end
    end

    // Entry payload: only meaningful while valid_q is set, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            funct3_q <= wr_funct3_i;
            a_q      <= wr_a_i;
            b_q      <= wr_b_i;
            res_q    <= wr_res_i;
        end
    end

    assign hit_o = valid_q && (funct3_q == rd_funct3_i) &&
                   (a_q == rd_a_i) && (b_q == rd_b_i);
    assign hit_res_o = res_q;

endmodule

// File: rtl/m_ext_mul_ctrl.sv
// Execute-stage controller for RISC-V M-extension multiplies. Launches an
// operation on an external multiplier, stalls the pipeline until the result
// strobe arrives, and presents a one-cycle result_valid pulse.
// Optional feature: define MULT_CACHE_EN to add a one-entry result cache that
// lets an exact repeat of the last multiply complete without the multiplier.
module m_ext_mul_ctrl
    import m_ext_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic [2:0]      mulsel,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic            mul_ready,
    input  logic [XLEN-1:0] mul_res
);

    state_e          state_q;
    mulsel_e         mulsel_q;
    logic [XLEN-1:0] mul_a_q;
    logic [XLEN-1:0] mul_b_q;
    logic [XLEN-1:0] result_q;
    logic            result_valid_q;

    logic            is_mul_op;
    logic            in_idle;
    logic            accept;
    logic            drain_hold;
    logic            cache_hit;
    logic [XLEN-1:0] cache_res;

    // Divides (funct3[2]=1) are not ours and pass through untouched.
    assign is_mul_op = valid_in && !funct3[2];
    assign in_idle   = (state_q == ST_IDLE);
    // A still-pulsing mul_ready belongs to an abandoned operation; never
    // launch while it is high so the strobe cannot be misattributed.
    assign accept     = !rst && is_mul_op && in_idle && !flush && !mul_ready;
    assign drain_hold = !rst && is_mul_op && in_idle && mul_ready;

`ifdef MULT_CACHE_EN
    logic cache_wr;

    assign cache_wr = !rst && (state_q == ST_WAIT) && !flush && mul_ready;

    m_ext_result_cache u_cache (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_en_i     (cache_wr),
        .wr_funct3_i (funct3_from_mulsel(mulsel_q)),
        .wr_a_i      (mul_a_q),
        .wr_b_i      (mul_b_q),
        .wr_res_i    (mul_res),
        .rd_funct3_i (funct3),
        .rd_a_i      (rs1_val),
        .rd_b_i      (rs2_val),
        .hit_o       (cache_hit),
        .hit_res_o   (cache_res)
    );
`else
    assign cache_hit = 1'b0;
    assign cache_res = '0;
`endif

    // Control FSM with registered multiplier request and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            mulsel_q       <= MULSEL_IDLE;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    result_valid_q <= 1'b0;
                    if (accept) begin
                        if (cache_hit) begin
                            state_q        <= ST_DONE;
                            result_q       <= cache_res;
                            result_valid_q <= 1'b1;
                        end else begin
                            state_q  <= ST_WAIT;
                            mulsel_q <= mulsel_from_funct3(funct3);
                            mul_a_q  <= rs1_val;
                            mul_b_q  <= rs2_val;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        state_q  <= ST_IDLE;
                        mulsel_q <= MULSEL_IDLE;
                        mul_a_q  <= '0;
                        mul_b_q  <= '0;
                    end else if (mul_ready) begin
                        state_q        <= ST_DONE;
                        result_q       <= mul_res;
                        result_valid_q <= 1'b1;
                        mulsel_q       <= MULSEL_IDLE;
                        mul_a_q        <= '0;
                        mul_b_q        <= '0;
                    end
                end
                ST_DONE: begin
                    state_q        <= ST_IDLE;
                    result_valid_q <= 1'b0;
                end
                default: begin
                    state_q        <= ST_IDLE;
                    mulsel_q       <= MULSEL_IDLE;
                    result_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall        = !rst && ((state_q == ST_WAIT) || accept || drain_hold);
    assign result_valid = result_valid_q && !flush;
    assign result       = result_q;
    assign mulsel       = mulsel_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;

endmodule

// File: tb/tb_m_ext_mul_ctrl.sv
// Self-checking bench for m_ext_mul_ctrl with a behavioural two-cycle-strobe
// multiplier and a latency/cache reference model.
module tb_m_ext_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_val = 32'd0;
    logic [31:0] rs2_val = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic [2:0]  mulsel;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_ready;
    logic [31:0] mul_res;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

`ifdef MULT_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    m_ext_mul_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .funct3       (funct3),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .flush        (flush),
        .stall        (stall),
        .result       (result),
        .result_valid (result_valid),
        .mulsel       (mulsel),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_ready    (mul_ready),
        .mul_res      (mul_res)
    );

    // Architectural product of an M-extension multiply.
    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f3[1:0])
            2'd0:    p = 64'(ua * ub);
            2'd1:    p = 64'(sa * sb);
            2'd2:    p = 64'(sa * ub);
            default: p = 64'(ua * ub);
        endcase
        return (f3[1:0] == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Multiplier stand-in: sees a request one cycle after mulsel rises and
    // strobes mul_ready for two cycles, two cycles after that.
    logic [1:0]  mcnt = 2'd0;
    logic [31:0] mprod = 32'd0;
    always @(posedge clk) begin
        if (rst) mcnt <= 2'd0;
        else if (mcnt != 2'd0) mcnt <= mcnt + 2'd1;
        else if (mulsel != 3'd0) begin
            mcnt  <= 2'd1;
            mprod <= ref_mul(mulsel - 3'd1, mul_a, mul_b);
        end
    end
    assign mul_ready = (mcnt >= 2'd2);
    assign mul_res   = mul_ready ? mprod : 32'hDEAD_BEEF;

    // Observation record of the last run_op.
    logic [15:0] obs_stall, obs_rv, obs_selnz;
    logic [2:0]  obs_sel [16];
    logic [31:0] obs_res [16];
    int          obs_n;

    // Present one instruction from a negedge, hold it while stalled, record.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        valid_in = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; flush = 1'b0;
        obs_stall = '0; obs_rv = '0; obs_selnz = '0; obs_n = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            obs_stall[c] = stall;
            obs_rv[c]    = result_valid;
            obs_sel[c]   = mulsel;
            obs_selnz[c] = (mulsel != 3'd0);
            obs_res[c]   = result;
            obs_n        = c + 1;
            @(negedge clk);
            if (!obs_stall[c] && c > 0) break;
        end
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0; flush = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({stall, result_valid, mulsel, mul_a, mul_b, result} !== '0)
            $display("FAIL reset_held: stall=%b rv=%b sel=%0d a=%h b=%h res=%h required all 0",
                     stall, result_valid, mulsel, mul_a, mul_b, result);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({stall, result_valid, mulsel, mul_a, mul_b, result} !== '0)
            $display("FAIL reset_released: stall=%b rv=%b sel=%0d res=%h required all 0",
                     stall, result_valid, mulsel, result);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        run_op(3'b000, 32'd7, 32'd6);
        n_checks++;
        if ({obs_n, obs_stall, obs_rv, obs_selnz} !== {32'd5, 16'h000F, 16'h0010, 16'h000E})
            $display("FAIL mul_7x6_timing: n=%0d stall=%h rv=%h selnz=%h required 5 000f 0010 000e",
                     obs_n, obs_stall, obs_rv, obs_selnz);
        else n_pass++;
        n_checks++;
        if (obs_sel[1] !== 3'd1) $display("FAIL mul_7x6_sel: got %0d required 1", obs_sel[1]);
        else n_pass++;
        n_checks++;
        if (obs_res[4] !== 32'h0000_002A) $display("FAIL mul_7x6_res: got %h required 0000002a", obs_res[4]);
        else n_pass++;

        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++;
        if (obs_sel[1] !== 3'd4 || obs_rv !== 16'h0010 || obs_res[4] !== 32'hFFFF_FFFE)
            $display("FAIL mulhu_ones: sel=%0d rv=%h res=%h required 4 0010 fffffffe",
                     obs_sel[1], obs_rv, obs_res[4]);
        else n_pass++;

        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++;
        if (obs_sel[1] !== 3'd2 || obs_rv !== 16'h0010 || obs_res[4] !== 32'h0000_0000)
            $display("FAIL mulh_ones: sel=%0d rv=%h res=%h required 2 0010 00000000",
                     obs_sel[1], obs_rv, obs_res[4]);
        else n_pass++;

        run_op(3'b010, 32'hFFFF_FFFF, 32'd2);
        n_checks++;
        if (obs_sel[1] !== 3'd3 || obs_rv !== 16'h0010 || obs_res[4] !== 32'hFFFF_FFFF)
            $display("FAIL mulhsu_neg1x2: sel=%0d rv=%h res=%h required 3 0010 ffffffff",
                     obs_sel[1], obs_rv, obs_res[4]);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_back_to_back();
        int start;
        start = cyc;
        run_op(3'b000, 32'd3, 32'd4);
        n_checks++;
        if (obs_res[4] !== 32'd12) $display("FAIL b2b_first_res: got %h required 0000000c", obs_res[4]);
        else n_pass++;
        run_op(3'b011, 32'h0001_0000, 32'h0001_0000);
        n_checks++;
        if ({obs_n, obs_stall, obs_rv} !== {32'd5, 16'h000F, 16'h0010} || obs_sel[1] !== 3'd4)
            $display("FAIL b2b_second_timing: n=%0d stall=%h rv=%h sel=%0d required 5 000f 0010 4",
                     obs_n, obs_stall, obs_rv, obs_sel[1]);
        else n_pass++;
        n_checks++;
        if (obs_res[4] !== 32'd1) $display("FAIL b2b_second_res: got %h required 00000001", obs_res[4]);
        else n_pass++;
        n_checks++;
        if (cyc - start !== 10) $display("FAIL b2b_cycles: got %0d required 10", cyc - start);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_flush();
        // Flush in WAIT, then a new multiply that must wait out the stale strobe.
        for (int c = 0; c < 10; c++) begin
            valid_in = 1'b1; funct3 = 3'b000;
            rs1_val  = (c < 3) ? 32'd7 : 32'd9;
            rs2_val  = (c < 3) ? 32'd6 : 32'd3;
            flush    = (c == 2);
            #1;
            n_checks++;
            if (stall !== (c != 9) || result_valid !== (c == 9))
                $display("FAIL flush_wait_c%0d: stall=%b rv=%b required %b %b",
                         c, stall, result_valid, c != 9, c == 9);
            else n_pass++;
            if (c == 3) begin
                n_checks++;
                if (mulsel !== 3'd0) $display("FAIL flush_sel_cleared: got %0d required 0", mulsel);
                else n_pass++;
            end
            if (c == 6) begin
                n_checks++;
                if (mulsel !== 3'd1 || mul_a !== 32'd9) $display("FAIL flush_relaunch: sel=%0d a=%h required 1 00000009", mulsel, mul_a);
                else n_pass++;
            end
            if (c == 9) begin
                n_checks++;
                if (result !== 32'd27) $display("FAIL flush_next_res: got %h required 0000001b", result);
                else n_pass++;
            end
            @(negedge clk);
        end
        // Flush while the result is being presented.
        for (int c = 0; c < 5; c++) begin
            valid_in = 1'b1; funct3 = 3'b000; rs1_val = 32'd5; rs2_val = 32'd5;
            flush = (c == 4);
            #1;
            if (c == 4) begin
                n_checks++;
                if (result_valid !== 1'b0 || stall !== 1'b0)
                    $display("FAIL flush_done: rv=%b stall=%b required 0 0", result_valid, stall);
                else n_pass++;
            end
            @(negedge clk);
        end
        // Flush while idle blocks the accept.
        valid_in = 1'b1; funct3 = 3'b000; rs1_val = 32'd5; rs2_val = 32'd6; flush = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL flush_idle_stall: got %b required 0", stall);
        else n_pass++;
        @(negedge clk);
        valid_in = 1'b0; flush = 1'b0;
        #1;
        n_checks++;
        if (mulsel !== 3'd0 || stall !== 1'b0) $display("FAIL flush_idle_block: sel=%0d stall=%b required 0 0", mulsel, stall);
        else n_pass++;
        idle(4);
    endtask

    task automatic test_divide_and_rst();
        for (int i = 0; i < 4; i++) begin
            run_op(3'($urandom_range(4, 7)), $urandom, $urandom);
            n_checks++;
            if ({obs_n, obs_stall, obs_rv, obs_selnz} !== {32'd2, 16'h0, 16'h0, 16'h0})
                $display("FAIL divide_ignored_%0d: n=%0d stall=%h rv=%h selnz=%h required 2 0 0 0",
                         i, obs_n, obs_stall, obs_rv, obs_selnz);
            else n_pass++;
        end
        for (int c = 0; c < 8; c++) begin
            valid_in = (c < 2); funct3 = 3'b000; rs1_val = 32'd7; rs2_val = 32'd6;
            rst = (c == 2);
            #1;
            if (c == 1) begin
                n_checks++;
                if (mulsel !== 3'd1) $display("FAIL rst_op_started: sel=%0d required 1", mulsel);
                else n_pass++;
            end
            if (c >= 3) begin
                n_checks++;
                if ({stall, result_valid, mulsel, mul_a, mul_b, result} !== '0)
                    $display("FAIL rst_mid_c%0d: stall=%b rv=%b sel=%0d a=%h b=%h res=%h required all 0",
                             c, stall, result_valid, mulsel, mul_a, mul_b, result);
                else n_pass++;
            end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0]  f3, pf3;
        logic [31:0] a, b, pa, pb, eres;
        logic        m_valid;
        logic [2:0]  m_f3;
        logic [31:0] m_a, m_b;
        int          en;
        logic [15:0] es, er, ez;
        bit          hit, have_prev;
        m_valid = 1'b0; m_f3 = '0; m_a = '0; m_b = '0;
        pf3 = '0; pa = '0; pb = '0; have_prev = 0;
        for (int i = 0; i < 40; i++) begin
            if (have_prev && $urandom_range(0, 3) == 0) begin
                f3 = pf3; a = pa; b = pb;
            end else begin
                f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
                a  = pick_operand();
                b  = pick_operand();
            end
            eres = ref_mul(f3, a, b);
            hit  = CACHE_ON && m_valid && m_f3 == f3 && m_a == a && m_b == b;
            if (f3[2]) begin
                en = 2; es = 16'h0; er = 16'h0; ez = 16'h0;
            end else if (hit) begin
                en = 2; es = 16'h1; er = 16'h2; ez = 16'h0;
            end else begin
                en = 5; es = 16'hF; er = 16'h10; ez = 16'hE;
                m_valid = 1'b1; m_f3 = f3; m_a = a; m_b = b;
            end
            run_op(f3, a, b);
            n_checks++;
            if ({obs_n, obs_stall, obs_rv, obs_selnz} !== {en, es, er, ez})
                $display("FAIL rand_%0d_timing: f3=%0d n=%0d stall=%h rv=%h selnz=%h required %0d %h %h %h",
                         i, f3, obs_n, obs_stall, obs_rv, obs_selnz, en, es, er, ez);
            else n_pass++;
            if (!f3[2]) begin
                n_checks++;
                if (obs_res[en-1] !== eres)
                    $display("FAIL rand_%0d_res: f3=%0d a=%h b=%h got %h required %h",
                             i, f3, a, b, obs_res[en-1], eres);
                else n_pass++;
                if (!hit) begin
                    n_checks++;
                    if (obs_sel[1] !== f3 + 3'd1)
                        $display("FAIL rand_%0d_sel: got %0d required %0d", i, obs_sel[1], f3 + 3'd1);
                    else n_pass++;
                end
            end
            pf3 = f3; pa = a; pb = b; have_prev = 1;
        end
        idle(2);
    endtask

`ifdef MULT_CACHE_EN
    task automatic test_cache();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_op(3'b000, 32'd7, 32'd6);
        run_op(3'b000, 32'd7, 32'd6);
        n_checks++;
        if ({obs_n, obs_stall, obs_rv, obs_selnz} !== {32'd2, 16'h1, 16'h2, 16'h0} || obs_res[1] !== 32'h2A)
            $display("FAIL cache_hit_7x6: n=%0d stall=%h rv=%h selnz=%h res=%h required 2 1 2 0 0000002a",
                     obs_n, obs_stall, obs_rv, obs_selnz, obs_res[1]);
        else n_pass++;
        run_op(3'b000, 32'd7, 32'd5);
        n_checks++;
        if ({obs_n, obs_stall, obs_rv} !== {32'd5, 16'hF, 16'h10} || obs_res[4] !== 32'h23)
            $display("FAIL cache_miss_7x5: n=%0d stall=%h rv=%h res=%h required 5 f 10 00000023",
                     obs_n, obs_stall, obs_rv, obs_res[4]);
        else n_pass++;
        valid_in = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        run_op(3'b000, 32'd7, 32'd5);
        n_checks++;
        if ({obs_n, obs_rv} !== {32'd2, 16'h2} || obs_res[1] !== 32'h23)
            $display("FAIL cache_survives_flush: n=%0d rv=%h res=%h required 2 2 00000023",
                     obs_n, obs_rv, obs_res[1]);
        else n_pass++;
        idle(2);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_flush();
        test_divide_and_rst();
        test_random();
`ifdef MULT_CACHE_EN
        test_cache();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
